pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 54 +++++
 rtl/pipe_slot.sv | 70 +++++++
 rtl/pipe_skid_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage_pkg
//
// Purpose:
//   Shared definitions for the two-slot skid pipeline stage: the occupancy
//   state encoding, the default lane-slice width, the per-cycle control bus
//   that the top derives from the handshake, and a helper that maps a state
//   onto the occupancy count reported on occupancy_o.
//
// Contents:
//   LANE_W        default payload bits per lane
//   OCC_W         width of the occupancy count
//   skid_state_e  EMPTY / ONE / TWO, encoded as the number of held bundles
//   skid_ctrl_t   push / pop / flush decisions for the current cycle
//   occOf()       state -> occupancy count
//
// Optional feature:
//   PIPE_SKID_PERF_EN is consumed by the top; nothing here depends on it.
// ---------------------------------------------------------------------------
package pipe_skid_stage_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned OCC_W  = 2;

  // The encoding equals the bundle count so the occupancy output is a
  // direct view of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Per-cycle decisions; flush is carried alongside so that the FSM and
  // both slots see a single consistent view of the cycle.
  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } skid_ctrl_t;

  // Map a state onto the value driven on occupancy_o.
  function automatic logic [OCC_W-1:0] occOf(input skid_state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//
// Purpose:
//   One bundle slot: a LANES-wide bank of per-lane valid bits plus the
//   matching payload. The top instantiates it twice, as the head (main)
//   slot and as the skid slot.
//
// Ports:
//   clock_i        rising-edge clock
//   reset_i        synchronous active-high reset, clears valid bits only
//   flush_i        clears every valid bit, overriding load and clear
//   load_i         capture load_valid_i / load_data_i as the new content
//   load_valid_i   per-lane valid to capture
//   load_data_i    payload to capture, lane i at [i*WIDTH +: WIDTH]
//   clear_i        per-lane clear of held valid bits (retirement)
//   valid_o        per-lane valid of the held bundle
//   data_o         held payload
//
// Notes:
//   Payload is deliberately left out of reset; its value only matters where
//   the matching valid bit is set.
// ---------------------------------------------------------------------------
module pipe_slot
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = LANE_W
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  logic [LANES-1:0]       load_valid_i,
  input  logic [LANES*WIDTH-1:0] load_data_i,
  input  logic [LANES-1:0]       clear_i,
  output logic [LANES-1:0]       valid_o,
  output logic [LANES*WIDTH-1:0] data_o
);

  logic [LANES-1:0]       r_valid;
  logic [LANES*WIDTH-1:0] r_data;

  // Valid bits: reset and flush empty the slot; a load replaces the whole
  // bundle; otherwise individual lanes drop out as they retire while the
  // rest hold their position.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (load_i) begin
      r_valid <= load_valid_i;
    end else begin
      r_valid <= r_valid & ~clear_i;
    end
  end

  // Payload only moves on a load; it is never cleared because a cleared
  // valid bit already marks the lane as don't-care.
  always_ff @(posedge clock_i) begin
    if (load_i) begin
      r_data <= load_data_i;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Purpose:
//   Two-slot skid buffer for a multi-lane issue bundle. The head bundle sits
//   in the main slot and drives out_*; a second bundle can wait in the skid
//   slot so that in_ready_o can be a pure register with no combinational
//   path from out_accept_i. Lanes of the head bundle retire independently;
//   the bundle pops once every valid lane has retired.
//
// Parameters:
//   LANES  issue lanes per bundle (1..4)
//   WIDTH  payload bits per lane
//
// Ports:
//   clock_i       rising-edge clock
//   reset_i       synchronous active-high reset
//   flush_i       drop every held bundle
//   in_valid_i    per-lane valid of the offered bundle
//   in_data_i     offered payload, lane i at [i*WIDTH +: WIDTH]
//   in_ready_o    registered; high while fewer than two bundles are held
//   out_valid_o   per-lane valid of the head bundle
//   out_data_o    head payload, same lane packing as in_data_i
//   out_accept_i  per-lane consume from downstream
//   occupancy_o   bundles held: 0, 1 or 2
//   stall_cnt_o   (PIPE_SKID_PERF_EN only) cycles with an offer refused
//   split_cnt_o   (PIPE_SKID_PERF_EN only) cycles with a partial retirement
//
// Configuration:
//   `define PIPE_SKID_PERF_EN adds the two saturating 32-bit counters.
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = LANE_W
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic [LANES-1:0]       in_valid_i,
  input  logic [LANES*WIDTH-1:0] in_data_i,
  output logic                   in_ready_o,
  output logic [LANES-1:0]       out_valid_o,
  output logic [LANES*WIDTH-1:0] out_data_o,
  input  logic [LANES-1:0]       out_accept_i,
  output logic [OCC_W-1:0]       occupancy_o
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            split_cnt_o
`endif
);

  skid_state_e            r_state;
  skid_state_e            w_nextState;
  logic                   r_inReady;

  skid_ctrl_t             w_ctrl;
  logic [LANES-1:0]       w_retire;
  logic [LANES-1:0]       w_remain;

  logic                   w_mainLoad;
  logic                   w_mainFromSkid;
  logic                   w_skidLoad;
  logic [LANES-1:0]       w_mainLoadValid;
  logic [LANES*WIDTH-1:0] w_mainLoadData;

  logic [LANES-1:0]       w_mainValid;
  logic [LANES*WIDTH-1:0] w_mainData;
  logic [LANES-1:0]       w_skidValid;
  logic [LANES*WIDTH-1:0] w_skidData;
  logic [LANES-1:0]       w_skidClear;

  // Handshake decode. Accepts on lanes that are not valid are masked off
  // here, so they can neither retire anything nor cause a pop. The head
  // pops when no valid lane is left after this cycle's retirements; an
  // empty main slot never pops because it has no valid lane to start with.
  always_comb begin
    w_retire     = w_mainValid & out_accept_i;
    w_remain     = w_mainValid & ~out_accept_i;
    w_ctrl       = '0;
    w_ctrl.push  = r_inReady & (|in_valid_i);
    w_ctrl.pop   = (|w_mainValid) & ~(|w_remain);
    w_ctrl.flush = flush_i;
  end

  // Occupancy state register. in_ready_o is registered from the next state
  // rather than decoded from the current one, which keeps the downstream
  // accept out of the upstream ready path entirely.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= ST_EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != ST_TWO);
    end
  end

  // Next-state and slot steering. A push into an empty stage, or a push
  // that coincides with the head popping, lands straight in main so it is
  // visible next cycle. A push behind a head that stays goes to skid, and
  // a pop from TWO promotes skid into main on the same edge. Flush wins
  // over everything; the slots drop their valid bits on their own flush.
  always_comb begin
    w_nextState    = r_state;
    w_mainLoad     = 1'b0;
    w_mainFromSkid = 1'b0;
    w_skidLoad     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_ctrl.push) begin
          w_nextState = ST_ONE;
          w_mainLoad  = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_ctrl.push, w_ctrl.pop})
          2'b10: begin
            w_nextState = ST_TWO;
            w_skidLoad  = 1'b1;
          end
          2'b01: begin
            w_nextState = ST_EMPTY;
          end
          2'b11: begin
            w_nextState = ST_ONE;
            w_mainLoad  = 1'b1;
          end
          default: begin
            w_nextState = ST_ONE;
          end
        endcase
      end
      ST_TWO: begin
        if (w_ctrl.pop) begin
          w_nextState    = ST_ONE;
          w_mainLoad     = 1'b1;
          w_mainFromSkid = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_EMPTY;
      end
    endcase
    if (w_ctrl.flush) begin
      w_nextState    = ST_EMPTY;
      w_mainLoad     = 1'b0;
      w_mainFromSkid = 1'b0;
      w_skidLoad     = 1'b0;
    end
  end

  // Main slot source: the upstream bundle, or the waiting skid bundle when
  // the head pops out of TWO. Lane positions are carried unchanged.
  assign w_mainLoadValid = w_mainFromSkid ? w_skidValid : in_valid_i;
  assign w_mainLoadData  = w_mainFromSkid ? w_skidData  : in_data_i;

  // The skid bundle is never exposed downstream, so it never retires lanes.
  assign w_skidClear = '0;

  pipe_slot #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_mainSlot (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .flush_i      (w_ctrl.flush),
    .load_i       (w_mainLoad),
    .load_valid_i (w_mainLoadValid),
    .load_data_i  (w_mainLoadData),
    .clear_i      (w_retire),
    .valid_o      (w_mainValid),
    .data_o       (w_mainData)
  );

  pipe_slot #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_skidSlot (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .flush_i      (w_ctrl.flush),
    .load_i       (w_skidLoad),
    .load_valid_i (in_valid_i),
    .load_data_i  (in_data_i),
    .clear_i      (w_skidClear),
    .valid_o      (w_skidValid),
    .data_o       (w_skidData)
  );

  assign in_ready_o  = r_inReady;
  assign out_valid_o = w_mainValid;
  assign out_data_o  = w_mainData;
  assign occupancy_o = occOf(r_state);

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_splitCnt;
  logic        w_stallEvt;
  logic        w_splitEvt;

  // A stall is an offered bundle meeting a full stage; a split is a cycle
  // where the head loses some of its valid lanes but not all of them.
  assign w_stallEvt = (|in_valid_i) & ~r_inReady;
  assign w_splitEvt = (|w_retire) & (w_retire != w_mainValid);

  // Saturating event counters. Only reset clears them, so flush-heavy
  // traffic still accumulates statistics.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_stallCnt <= '0;
      r_splitCnt <= '0;
    end else begin
      if (w_stallEvt && (r_stallCnt != 32'hFFFF_FFFF)) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (w_splitEvt && (r_splitCnt != 32'hFFFF_FFFF)) begin
        r_splitCnt <= r_splitCnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stallCnt;
  assign split_cnt_o = r_splitCnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Purpose:
//   Self-checking bench for pipe_skid_stage (LANES=2, WIDTH=32). A queue of
//   bundles models the stage: the head of the queue is what downstream
//   should see, the queue length is the occupancy, and ready is simply
//   "fewer than two queued". Directed sequences cover the listed scenarios,
//   then randomized traffic with occasional flush and reset follows.
//   Counter checks are included when PIPE_SKID_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

  localparam int LANES = 2;
  localparam int WIDTH = 32;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic [1:0]  in_valid_i;
  logic [63:0] in_data_i;
  logic        in_ready_o;
  logic [1:0]  out_valid_o;
  logic [63:0] out_data_o;
  logic [1:0]  out_accept_i;
  logic [1:0]  occupancy_o;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] split_cnt_o;
`endif

  pipe_skid_stage #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_accept_i (out_accept_i),
    .occupancy_o  (occupancy_o)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .split_cnt_o  (split_cnt_o)
`endif
  );

  // Free-running clock, period 10.
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] d;
  } bundle_t;

  bundle_t     mdlQ[$];
  logic [31:0] mdlStall;
  logic [31:0] mdlSplit;
  logic        lastPush;
  int          compareCount;
  int          failCount;

  // Watchdog so the run always ends even if the clock loop stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] expValid();
    return (mdlQ.size() > 0) ? mdlQ[0].v : 2'b00;
  endfunction

  function automatic logic [63:0] laneMask(input logic [1:0] v);
    return {{32{v[1]}}, {32{v[0]}}};
  endfunction

  // Compare every observable output against the queue model.
  task automatic checkAll();
    logic [1:0]  ev;
    logic [63:0] ed;
    ev = expValid();
    ed = (mdlQ.size() > 0) ? mdlQ[0].d : 64'd0;
    checkOutput("out_valid", 64'(out_valid_o), 64'(ev));
    checkOutput("out_data", out_data_o & laneMask(ev), ed & laneMask(ev));
    checkOutput("in_ready", 64'(in_ready_o), 64'(mdlQ.size() < 2));
    checkOutput("occupancy", 64'(occupancy_o), 64'(mdlQ.size()));
`ifdef PIPE_SKID_PERF_EN
    checkOutput("stall_cnt", 64'(stall_cnt_o), 64'(mdlStall));
    checkOutput("split_cnt", 64'(split_cnt_o), 64'(mdlSplit));
`endif
  endtask

  // One cycle: check current outputs, drive the inputs, clock, then advance
  // the model by the rules of the stage.
  task automatic applyStimulus(input logic rst, input logic fl, input logic [1:0] iv,
                               input logic [63:0] id, input logic [1:0] acc);
    logic [1:0] ev;
    logic [1:0] ret;
    logic [1:0] rem;
    logic       pop;
    logic       push;
    logic       stallEvt;
    logic       splitEvt;
    bundle_t    head;
    bundle_t    nb;
    checkAll();
    reset_i      = rst;
    flush_i      = fl;
    in_valid_i   = iv;
    in_data_i    = id;
    out_accept_i = acc;
    ev       = expValid();
    ret      = ev & acc;
    rem      = ev & ~acc;
    pop      = (mdlQ.size() > 0) && (rem == 2'b00);
    push     = (mdlQ.size() < 2) && (iv != 2'b00);
    stallEvt = (iv != 2'b00) && (mdlQ.size() >= 2);
    splitEvt = (ret != 2'b00) && (ret != ev);
    @(posedge clock_i);
    #1;
    if (rst) begin
      mdlQ.delete();
      mdlStall = 32'd0;
      mdlSplit = 32'd0;
      lastPush = 1'b0;
    end else begin
      if (stallEvt && mdlStall != 32'hFFFF_FFFF) mdlStall = mdlStall + 32'd1;
      if (splitEvt && mdlSplit != 32'hFFFF_FFFF) mdlSplit = mdlSplit + 32'd1;
      if (fl) begin
        mdlQ.delete();
        lastPush = 1'b0;
      end else begin
        if (mdlQ.size() > 0) begin
          head   = mdlQ[0];
          head.v = rem;
          mdlQ[0] = head;
        end
        if (pop) void'(mdlQ.pop_front());
        if (push) begin
          nb.v = iv;
          nb.d = id;
          mdlQ.push_back(nb);
        end
        lastPush = push;
      end
    end
  endtask

  initial begin
    int nxt;
    compareCount = 0;
    failCount    = 0;
    mdlStall     = 32'd0;
    mdlSplit     = 32'd0;
    lastPush     = 1'b0;
    reset_i      = 1'b1;
    flush_i      = 1'b0;
    in_valid_i   = 2'b00;
    in_data_i    = 64'd0;
    out_accept_i = 2'b00;
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    // Reset state, then a single bundle through an empty stage.
    applyStimulus(1'b0, 1'b0, 2'b11, {32'hB, 32'hA}, 2'b11);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b11);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b00);

    // Four bundles against a blocked output, released later; the producer
    // holds its bundle until the model says it was taken.
    nxt = 1;
    for (int c = 0; c < 16; c++) begin
      if (nxt <= 4)
        applyStimulus(1'b0, 1'b0, 2'b11, {32'(nxt) + 32'h100, 32'(nxt)}, (c < 5) ? 2'b00 : 2'b11);
      else
        applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, (c < 5) ? 2'b00 : 2'b11);
      if (lastPush) nxt++;
    end

    // Split retirement: lane0 first, then lane1.
    applyStimulus(1'b0, 1'b0, 2'b11, {32'hD1, 32'hD0}, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b01);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b10);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b00);

    // Flush from TWO with a simultaneous full accept and offer.
    applyStimulus(1'b0, 1'b0, 2'b01, 64'h1111, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b10, 64'h2222_0000_0000, 2'b00);
    applyStimulus(1'b0, 1'b1, 2'b11, 64'h3333_0000_3333, 2'b11);
    repeat (3) applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b11);

    // Stall, drain to ONE, then reset with a push pending.
    applyStimulus(1'b0, 1'b0, 2'b11, 64'h4, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b11, 64'h5, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b11, 64'h6, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b11);
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h7, 2'b00);

    // Idle with ready high.
    repeat (5) applyStimulus(1'b0, 1'b0, 2'b00, 64'd0, 2'b11);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                    2'($urandom_range(0, 3)),
                    {$urandom, $urandom},
                    2'($urandom_range(0, 3)));
    end
    checkAll();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
